// File: rtl/gauss_conv_engine.sv
// -----------------------------------------------------------------------------
// gauss_conv_engine
//
// Purpose:
//   Convolves one KSIZE x KSIZE pixel window with a runtime-programmable
//   coefficient bank. Each window takes KSIZE cycles, one kernel row per cycle.
//   The result is normalised by SHIFT and saturated to OUT_WIDTH. It is then
//   emitted as a single output event with valid/ready backpressure.
//
//   The coefficients are double-buffered. Writes go to a shadow bank. A commit
//   request copies the shadow bank into the active bank on the next cycle in
//   which the engine is idle. A window that is already in flight therefore
//   always finishes with the coefficients it started with.
//
// Ports:
//   clk                  clock
//   rst_n                asynchronous active-low reset
//   in_window_value      flattened window; pixel (r,c) at (r*KSIZE+c)*DATA_WIDTH
//   in_window_valid      window present
//   in_window_addr       window centre address, carried to the output
//   window_req           engine can accept a window this cycle
//   out_event_value      normalised, saturated convolution result
//   out_event_valid      result valid (held until ready_for_new_event)
//   out_event_addr       address of the window that produced the result
//   ready_for_new_event  downstream ready
//   coef_wr_en           shadow coefficient write strobe
//   coef_wr_idx          coefficient index r*KSIZE+c (out-of-range ignored)
//   coef_wr_data         coefficient value
//   coef_commit          request shadow -> active copy
//   coef_pending         a commit is requested but not yet applied
// -----------------------------------------------------------------------------
module gauss_conv_engine #(
    parameter int KSIZE      = 7,
    parameter int DATA_WIDTH = 4,
    parameter int COEF_WIDTH = 10,
    parameter int SHIFT      = 8,
    parameter int OUT_WIDTH  = DATA_WIDTH + 12,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(KSIZE*KSIZE),
    parameter int IDX_WIDTH  = $clog2(KSIZE*KSIZE)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   in_window_value,
    input  logic                                in_window_valid,
    input  logic [15:0]                         in_window_addr,
    output logic                                window_req,
    output logic [OUT_WIDTH-1:0]                out_event_value,
    output logic                                out_event_valid,
    output logic [15:0]                         out_event_addr,
    input  logic                                ready_for_new_event,
    input  logic                                coef_wr_en,
    input  logic [IDX_WIDTH-1:0]                coef_wr_idx,
    input  logic [COEF_WIDTH-1:0]               coef_wr_data,
    input  logic                                coef_commit,
    output logic                                coef_pending
);

    localparam int NPIX   = KSIZE * KSIZE;
    localparam int CENTRE = (NPIX - 1) / 2;
    localparam int ROW_W  = $clog2(KSIZE);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

    // Unity gain in the fixed-point format implied by SHIFT
    localparam logic [COEF_WIDTH-1:0] IDENT_COEF = COEF_WIDTH'(1 << SHIFT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROW  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]                     r_state;
    logic [ROW_W-1:0]               r_row;
    logic [ACC_WIDTH-1:0]           r_acc;
    logic [NPIX*DATA_WIDTH-1:0]     r_window;
    logic [15:0]                    r_addr;
    logic [OUT_WIDTH-1:0]           r_out_value;
    logic                           r_out_valid;
    logic [15:0]                    r_out_addr;
    logic                           r_pending;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    logic w_window_req;
    logic w_accept;
    logic w_do_copy;
    logic w_last_row;

    // Only registered state feeds window_req, so no input reaches it
    // combinationally.
    assign w_window_req = (r_state == S_IDLE) && !r_pending;
    assign w_accept     = in_window_valid && w_window_req;
    // A pending commit blocks window_req. The copy therefore never coincides
    // with an accept.
    assign w_do_copy    = (r_state == S_IDLE) && r_pending;
    assign w_last_row   = (r_row == ROW_W'(KSIZE - 1));

    // -------------------------------------------------------------------------
    // Coefficient banks (shadow + active), both reset to the identity kernel
    // -------------------------------------------------------------------------
    logic [COEF_WIDTH-1:0] w_active [NPIX];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_bank
            localparam logic [COEF_WIDTH-1:0] RST_VAL =
                (gi == CENTRE) ? IDENT_COEF : '0;

            logic [COEF_WIDTH-1:0] r_shadow_coef;
            logic [COEF_WIDTH-1:0] r_active_coef;

            // The copy reads the shadow value from before this edge. A write
            // made in the commit cycle has already landed one edge earlier.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shadow_coef <= RST_VAL;
                    r_active_coef <= RST_VAL;
                end else begin
                    // No element matches an index >= NPIX, so such writes are
                    // dropped.
                    if (coef_wr_en && (coef_wr_idx == IDX_WIDTH'(gi))) begin
                        r_shadow_coef <= coef_wr_data;
                    end
                    if (w_do_copy) begin
                        r_active_coef <= r_shadow_coef;
                    end
                end
            end

            assign w_active[gi] = r_active_coef;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Row datapath: select the current kernel row, KSIZE multipliers, then sum
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_pix      [NPIX];
    logic [COEF_WIDTH-1:0] w_row_coef [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0] w_row_pix  [KSIZE][KSIZE];
    logic [PROD_W-1:0]     w_prod     [KSIZE];
    logic [ACC_WIDTH-1:0]  w_partial  [KSIZE+1];
    logic [ACC_WIDTH-1:0]  w_acc_next;
    logic [ACC_WIDTH-1:0]  w_shifted;
    logic [OUT_WIDTH-1:0]  w_sat_value;

    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_pix
            assign w_pix[gi] = r_window[gi*DATA_WIDTH +: DATA_WIDTH];
        end

        for (gi = 0; gi < KSIZE; gi++) begin : g_row
            for (gj = 0; gj < KSIZE; gj++) begin : g_col
                assign w_row_coef[gi][gj] = w_active[gi*KSIZE + gj];
                assign w_row_pix[gi][gj]  = w_pix[gi*KSIZE + gj];
            end
        end

        assign w_partial[0] = '0;
        for (gi = 0; gi < KSIZE; gi++) begin : g_mac
            assign w_prod[gi] = PROD_W'(w_row_coef[r_row][gi]) *
                                PROD_W'(w_row_pix[r_row][gi]);
            assign w_partial[gi+1] = w_partial[gi] + ACC_WIDTH'(w_prod[gi]);
        end
    endgenerate

    assign w_acc_next = r_acc + w_partial[KSIZE];
    assign w_shifted  = w_acc_next >> SHIFT;

    // The accumulator cannot overflow. Clamping happens only when the
    // normalised value does not fit in OUT_WIDTH.
    generate
        if (ACC_WIDTH > OUT_WIDTH) begin : g_sat
            assign w_sat_value = (|w_shifted[ACC_WIDTH-1:OUT_WIDTH]) ?
                                 {OUT_WIDTH{1'b1}} : w_shifted[OUT_WIDTH-1:0];
        end else begin : g_nosat
            assign w_sat_value = OUT_WIDTH'(w_shifted);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_acc       <= '0;
            r_window    <= '0;
            r_addr      <= '0;
            r_out_value <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_window <= in_window_value;
                        r_addr   <= in_window_addr;
                        r_acc    <= '0;
                        r_row    <= '0;
                        r_state  <= S_ROW;
                    end
                end
                S_ROW: begin
                    if (w_last_row) begin
                        r_out_value <= w_sat_value;
                        r_out_addr  <= r_addr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_acc <= w_acc_next;
                        r_row <= r_row + ROW_W'(1);
                    end
                end
                S_OUT: begin
                    // value/addr stay put after the handshake. Only valid
                    // qualifies them.
                    if (ready_for_new_event) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A commit in the copy cycle is a fresh request and keeps pending set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (coef_commit) begin
            r_pending <= 1'b1;
        end else if (w_do_copy) begin
            r_pending <= 1'b0;
        end
    end

    assign window_req      = w_window_req;
    assign out_event_value = r_out_value;
    assign out_event_valid = r_out_valid;
    assign out_event_addr  = r_out_addr;
    assign coef_pending    = r_pending;

endmodule

// File: tb/tb_gauss_conv_engine.sv
// -----------------------------------------------------------------------------
// tb_gauss_conv_engine
//
// Two engines share the clock, reset and coefficient bus:
//   - dut_a uses the default parameters.
//   - dut_b has OUT_WIDTH=8, so saturation can be reached.
// When a window is accepted, the expected result is pushed into a queue.
// A monitor pops and compares that result at each output handshake.
// The reference model computes the full 2-D dot product directly from a
// coefficient-bank model.
// -----------------------------------------------------------------------------
module tb_gauss_conv_engine;

    localparam int K   = 7;
    localparam int DW  = 4;
    localparam int CW  = 10;
    localparam int SH  = 8;
    localparam int OWA = 16;
    localparam int OWB = 8;
    localparam int NP  = K * K;
    localparam int IW  = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // dut_a
    logic [NP*DW-1:0] a_win;
    logic             a_valid;
    logic [15:0]      a_addr;
    logic             a_ready;
    logic             a_req;
    logic [OWA-1:0]   a_val;
    logic             a_ovalid;
    logic [15:0]      a_oaddr;
    logic             a_pending;
    // dut_b
    logic [NP*DW-1:0] b_win;
    logic             b_valid;
    logic [15:0]      b_addr;
    logic             b_ready;
    logic             b_req;
    logic [OWB-1:0]   b_val;
    logic             b_ovalid;
    logic [15:0]      b_oaddr;
    logic             b_pending;
    // shared coefficient bus
    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic [CW-1:0]    wr_data;
    logic             commit;

    gauss_conv_engine dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_window_value(a_win), .in_window_valid(a_valid), .in_window_addr(a_addr),
        .window_req(a_req),
        .out_event_value(a_val), .out_event_valid(a_ovalid), .out_event_addr(a_oaddr),
        .ready_for_new_event(a_ready),
        .coef_wr_en(wr_en), .coef_wr_idx(wr_idx), .coef_wr_data(wr_data),
        .coef_commit(commit), .coef_pending(a_pending)
    );

    gauss_conv_engine #(.OUT_WIDTH(OWB)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_window_value(b_win), .in_window_valid(b_valid), .in_window_addr(b_addr),
        .window_req(b_req),
        .out_event_value(b_val), .out_event_valid(b_ovalid), .out_event_addr(b_oaddr),
        .ready_for_new_event(b_ready),
        .coef_wr_en(wr_en), .coef_wr_idx(wr_idx), .coef_wr_data(wr_data),
        .coef_commit(commit), .coef_pending(b_pending)
    );

    // -------------------------------------------------------------------------
    // Reference model and scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        longint      v;
        logic [15:0] a;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned m_active [NP];
    int unsigned m_shadow [NP];
    bit          m_pending;
    int unsigned cur_pix  [NP];
    int          checks = 0;
    int          errors = 0;
    bit          rand_ready = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_active[i] = (i == (NP - 1) / 2) ? (32'd1 << SH) : 32'd0;
            m_shadow[i] = m_active[i];
        end
        m_pending = 1'b0;
    endtask

    function automatic longint ref_conv(input int ow);
        longint s = 0;
        longint mx;
        for (int i = 0; i < NP; i++) s += longint'(m_active[i]) * longint'(cur_pix[i]);
        s  = s >> SH;
        mx = (longint'(1) << ow) - 1;
        if (s > mx) s = mx;
        return s;
    endfunction

    function automatic logic [NP*DW-1:0] pack_pix();
        logic [NP*DW-1:0] v = '0;
        for (int i = 0; i < NP; i++) v[i*DW +: DW] = DW'(cur_pix[i]);
        return v;
    endfunction

    task automatic rand_pix();
        for (int i = 0; i < NP; i++) cur_pix[i] = $urandom_range(0, 15);
    endtask

    // Monitor: a negedge with valid && ready means a handshake at the next
    // posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && a_ovalid && a_ready) begin
                if (qa.size() == 0) begin
                    chk("unexpected_out_a", longint'(a_val), -1);
                end else begin
                    e = qa.pop_front();
                    chk("out_value_a", longint'(a_val), e.v);
                    chk("out_addr_a", longint'(a_oaddr), longint'(e.a));
                    $display("A out value=%0d addr=%h (exp %0d/%h)", a_val, a_oaddr, e.v, e.a);
                end
            end
            if (rst_n && b_ovalid && b_ready) begin
                if (qb.size() == 0) begin
                    chk("unexpected_out_b", longint'(b_val), -1);
                end else begin
                    e = qb.pop_front();
                    chk("out_value_b", longint'(b_val), e.v);
                    chk("out_addr_b", longint'(b_oaddr), longint'(e.a));
                    $display("B out value=%0d addr=%h (exp %0d/%h)", b_val, b_oaddr, e.v, e.a);
                end
            end
        end
    end

    // Random backpressure during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) a_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic wr(input int idx, input int data);
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_idx  = IW'(idx);
        wr_data = CW'(data);
        if (idx < NP) m_shadow[idx] = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        @(posedge clk);
        #1;
        commit    = 1'b1;
        m_pending = 1'b1;
        @(posedge clk);
        #1;
        commit = 1'b0;
    endtask

    // Presents cur_pix on dut_a and waits for the accept edge. It returns at
    // accept edge + #1.
    task automatic send_a(input logic [15:0] addr, output longint expv);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        a_win   = pack_pix();
        a_addr  = addr;
        a_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (a_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout_a", 0, 1);
        if (m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        expv = ref_conv(OWA);
        qa.push_back('{expv, addr});
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        bit ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (a_req && qa.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout_a", 0, 1);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        longint ev;
        longint ev1;
        logic [15:0] ad1;
        bit ok;

        a_win = '0; a_valid = 0; a_addr = '0; a_ready = 1;
        b_win = '0; b_valid = 0; b_addr = '0; b_ready = 1;
        wr_en = 0; wr_idx = '0; wr_data = '0; commit = 0;
        model_reset();

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid_a", longint'(a_ovalid), 0);
        chk("rst_value_a", longint'(a_val), 0);
        chk("rst_addr_a", longint'(a_oaddr), 0);
        chk("rst_pending_a", longint'(a_pending), 0);
        chk("rst_valid_b", longint'(b_ovalid), 0);

        // Identity kernel, single hot pixel; latency and window_req timing
        for (int i = 0; i < NP; i++) cur_pix[i] = 0;
        cur_pix[24] = 9;
        send_a(16'h1234, ev);
        $display("T1 accept addr=1234 exp=%0d", ev);
        for (int k = 1; k <= K; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("latency_valid", longint'(a_ovalid), (k == K) ? 1 : 0);
            chk("busy_req_low", longint'(a_req), 0);
        end
        @(negedge clk);
        chk("req_after_handshake", longint'(a_req), 1);

        // Uniform bank of 5 plus ignored out-of-range writes; commit in IDLE
        for (int i = 0; i < NP; i++) wr(i, 5);
        wr(49, 1023);
        wr(63, 1023);
        do_commit();
        @(negedge clk);
        chk("commit_pending_hi", longint'(a_pending), 1);
        chk("commit_req_lo", longint'(a_req), 0);
        @(negedge clk);
        chk("commit_pending_lo", longint'(a_pending), 0);
        chk("commit_req_hi", longint'(a_req), 1);
        for (int i = 0; i < NP; i++) cur_pix[i] = 15;
        send_a(16'hBEEF, ev);
        $display("T2 accept addr=beef exp=%0d", ev);
        wait_idle_a();

        // Full-scale bank: saturates on the 8-bit instance, not on the 16-bit one
        for (int i = 0; i < NP; i++) wr(i, 1023);
        do_commit();
        repeat (3) @(posedge clk);
        m_active  = m_shadow;
        m_pending = 1'b0;
        #1;
        b_win   = pack_pix();
        b_addr  = 16'h0B0B;
        b_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (b_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout_b", 0, 1);
        qb.push_back('{ref_conv(OWB), 16'h0B0B});
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        $display("T3 B accept exp=%0d", ref_conv(OWB));
        send_a(16'h0A0A, ev);
        $display("T3 A accept exp=%0d", ev);
        wait_idle_a();
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (qb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("out_timeout_b", 0, 1);

        // Backpressure: the output is held while a second window waits
        a_ready = 1'b0;
        rand_pix();
        ad1 = 16'($urandom);
        send_a(ad1, ev1);
        $display("T4 accept w1 addr=%h exp=%0d", ad1, ev1);
        rand_pix();
        a_win   = pack_pix();
        a_addr  = 16'h2222;
        a_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (a_ovalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("out_timeout_bp", 0, 1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("hold_valid", longint'(a_ovalid), 1);
            chk("hold_value", longint'(a_val), ev1);
            chk("hold_addr", longint'(a_oaddr), longint'(ad1));
            chk("hold_req_low", longint'(a_req), 0);
        end
        @(posedge clk);
        #1;
        a_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("req_after_release", longint'(a_req), 1);
        qa.push_back('{ref_conv(OWA), 16'h2222});
        $display("T4 accept w2 addr=2222 exp=%0d", ref_conv(OWA));
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        wait_idle_a();

        // Identity bank; a write plus commit during ROW is deferred
        for (int i = 0; i < NP; i++) wr(i, (i == 24) ? 256 : 0);
        do_commit();
        rand_pix();
        send_a(16'h5555, ev);
        $display("T5 accept w1 exp=%0d", ev);
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_idx = IW'(24); wr_data = CW'(512); commit = 1'b1;
        m_shadow[24] = 512;
        m_pending    = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; commit = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("defer_pending", longint'(a_pending), 1);
            chk("defer_req_low", longint'(a_req), 0);
        end
        @(negedge clk);
        chk("copy_cycle_pending", longint'(a_pending), 1);
        chk("copy_cycle_req", longint'(a_req), 0);
        @(negedge clk);
        chk("copy_done_pending", longint'(a_pending), 0);
        chk("copy_done_req", longint'(a_req), 1);
        rand_pix();
        cur_pix[24] = 3;
        send_a(16'h6666, ev);
        $display("T5 accept w2 exp=%0d", ev);
        wait_idle_a();

        // Async reset mid-ROW with a commit pending
        rand_pix();
        send_a(16'h7777, ev);
        $display("T6 accept (to be abandoned) exp=%0d", ev);
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_idx = '0; wr_data = CW'(100); commit = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; commit = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", longint'(a_ovalid), 0);
        chk("async_rst_value", longint'(a_val), 0);
        chk("async_rst_addr", longint'(a_oaddr), 0);
        chk("async_rst_pending", longint'(a_pending), 0);
        qa.delete();
        qb.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            chk("no_stale_out", longint'(a_ovalid), 0);
        end
        rand_pix();
        cur_pix[24] = 7;
        send_a(16'h0007, ev);
        $display("T6 accept after reset exp=%0d", ev);
        wait_idle_a();
        // The shadow bank must also be the identity after reset
        do_commit();
        rand_pix();
        cur_pix[24] = 11;
        send_a(16'h000B, ev);
        $display("T6 shadow identity exp=%0d", ev);
        wait_idle_a();

        // Random phase: random banks, random windows, random backpressure
        rand_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                wait_idle_a();
                for (int w = 0; w < 6; w++) wr($urandom_range(0, 63), $urandom_range(0, 1023));
                do_commit();
            end
            rand_pix();
            send_a(16'($urandom), ev);
            $display("R%0d accept exp=%0d", t, ev);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        a_ready = 1'b1;
        wait_idle_a();
        chk("queue_a_drained", longint'(qa.size()), 0);
        chk("queue_b_drained", longint'(qb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
